// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - 32-bit radix-2 restoring divider, signed/unsigned, 33-cycle latency
// Optional macro ITER_DIV_ZERO_FAST_EN: divide-by-zero skips the iteration loop (busy for 1 cycle).
module iter_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        sign,
  output logic        busy,
  output logic [63:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic [32:0] rem;
  logic [31:0] quo;
  logic [31:0] b_mag;
  logic [31:0] a_keep;
  logic        b_zero;
  logic        neg_q;
  logic        neg_r;

  logic [31:0] a_in_mag;
  logic [31:0] b_in_mag;
  logic [33:0] rem_sh;
  logic [33:0] diff;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  // Operand magnitudes at the request, one restoring trial step, and the final sign fix-up
  always_comb begin
    a_in_mag = (sign && A[31]) ? (~A + 32'd1) : A;
    b_in_mag = (sign && B[31]) ? (~B + 32'd1) : B;
    rem_sh   = {rem, quo[31]};
    diff     = rem_sh - {2'b00, b_mag};
    q_fix    = neg_q ? (~quo + 32'd1) : quo;
    r_fix    = neg_r ? (~rem[31:0] + 32'd1) : rem[31:0];
  end

  // Control FSM and datapath: launch, iterate 32 steps, correct signs and publish the result
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      result <= 64'd0;
      cnt    <= 6'd0;
      rem    <= 33'd0;
      quo    <= 32'd0;
      b_mag  <= 32'd0;
      a_keep <= 32'd0;
      b_zero <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rem    <= 33'd0;
            quo    <= a_in_mag;
            b_mag  <= b_in_mag;
            a_keep <= A;
            b_zero <= (B == 32'd0);
            neg_q  <= sign & (A[31] ^ B[31]);
            neg_r  <= sign & A[31];
            busy   <= 1'b1;
`ifdef ITER_DIV_ZERO_FAST_EN
            if (B == 32'd0) begin
              state <= S_FIX;
              cnt   <= 6'd0;
            end else begin
              state <= S_DIV;
              cnt   <= 6'd32;
            end
`else
            state <= S_DIV;
            cnt   <= 6'd32;
`endif
          end
        end
        S_DIV: begin
          rem <= diff[33] ? rem_sh[32:0] : diff[32:0];
          quo <= {quo[30:0], ~diff[33]};
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) state <= S_FIX;
        end
        S_FIX: begin
          // Divide-by-zero bypasses sign correction: quotient all ones, remainder is the raw dividend
          result <= b_zero ? {a_keep, 32'hFFFF_FFFF} : {r_fix, q_fix};
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - self-checking bench for iter_divider (vector table, corner sequences, random vs model)
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        sign;
  logic        busy;
  logic [63:0] result;

  int n_cmp  = 0;
  int n_fail = 0;

  iter_divider dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .A      (A),
    .B      (B),
    .sign   (sign),
    .busy   (busy),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] res;
    int          cyc;
  } vec_t;

  vec_t tbl[8];

`ifdef ITER_DIV_ZERO_FAST_EN
  localparam int ZERO_CYC = 1;
`else
  localparam int ZERO_CYC = 33;
`endif

  function automatic int exp_cyc(input logic [31:0] b);
    return (b == 32'd0) ? ZERO_CYC : 33;
  endfunction

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint x, y, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one start pulse and count the cycles busy reads high (bounded)
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [63:0] res, output int cyc);
    @(posedge clk); #1;
    start = 1'b1; A = a; B = b; sign = s;
    @(posedge clk); #1;
    start = 1'b0; A = $urandom; B = $urandom; sign = $urandom_range(0, 1);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(posedge clk); #1;
    end
    res = result;
  endtask

  logic [63:0] r;
  logic [63:0] held;
  int          c;
  logic        stable;
  logic [31:0] ra, rb;
  logic        rs;

  initial begin
    tbl[0] = '{32'd100,        32'd7,          1'b0, 64'h00000002_0000000E, 33};
    tbl[1] = '{32'hFFFF_FFF9,  32'h0000_0002,  1'b1, 64'hFFFFFFFF_FFFFFFFD, 33};
    tbl[2] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 64'h00000000_80000000, 33};
    tbl[3] = '{32'h1234_5678,  32'd0,          1'b1, 64'h12345678_FFFFFFFF, exp_cyc(0)};
    tbl[4] = '{32'hFFFF_FF9C,  32'd7,          1'b1, 64'hFFFFFFFE_FFFFFFF2, 33};
    tbl[5] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 64'h00000000_FFFFFFFF, 33};
    tbl[6] = '{32'd5,          32'd10,         1'b0, 64'h00000005_00000000, 33};
    tbl[7] = '{32'hFFFF_FF00,  32'd0,          1'b1, 64'hFFFFFF00_FFFFFFFF, exp_cyc(0)};

    reset = 1'b1; start = 1'b0; A = '0; B = '0; sign = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_int("reset_busy", int'(busy), 0);
    check64("reset_result", result, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_div(tbl[i].a, tbl[i].b, tbl[i].s, r, c);
      check64($sformatf("vec%0d_result", i), r, tbl[i].res);
      check_int($sformatf("vec%0d_busy_cycles", i), c, tbl[i].cyc);
    end

    // Result holds after completion while idle
    held = result;
    repeat (5) @(posedge clk);
    #1;
    check64("idle_hold", result, held);

    // Reset on the 10th DIV cycle aborts; then a fresh divide works
    @(posedge clk); #1;
    start = 1'b1; A = 32'd100; B = 32'd7; sign = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check_int("busy_after_start", int'(busy), 1);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_int("midreset_busy", int'(busy), 0);
    check64("midreset_result", result, 64'd0);
    run_div(32'd9, 32'd3, 1'b0, r, c);
    check64("after_reset_result", r, 64'h00000000_00000003);
    check_int("after_reset_busy", c, 33);

    // Start while busy is ignored; result untouched during DIV
    held = result;
    stable = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; A = 32'd100; B = 32'd7; sign = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (busy && c < 100) begin
      c++;
      if (c == 5) begin start = 1'b1; A = 32'd1; B = 32'd1; sign = 1'b1; end
      if (c == 6) start = 1'b0;
      if (c < 33 && result !== held) stable = 1'b0;
      @(posedge clk); #1;
    end
    check64("busy_start_result", result, 64'h00000002_0000000E);
    check_int("busy_start_cycles", c, 33);
    check_int("result_stable_in_div", int'(stable), 1);
    check_int("no_restart_busy", int'(busy), 0);

    // Reset wins over start on the same edge
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b1; A = 32'd50; B = 32'd5;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    check_int("reset_prio_busy", int'(busy), 0);
    check64("reset_prio_result", result, 64'd0);

    // Randomized against the arithmetic reference
    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom_range(0, 15);
        1: rb = 32'hFFFF_FFFF - $urandom_range(0, 3);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      rs = $urandom_range(0, 1);
      run_div(ra, rb, rs, r, c);
      check64($sformatf("rand%0d_result(a=%h b=%h s=%0d)", i, ra, rb, rs), r, ref_div(ra, rb, rs));
      check_int($sformatf("rand%0d_busy_cycles", i), c, exp_cyc(rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
